nonrestoring_divider_32: RTL and testbench
==========================================

// Module: nonrestoring_divider_32
// PURPOSE
//   Sequential non-restoring integer divider. Inverse companion to the Booth
//   multiplier: computes quotient and remainder of dividend / divisor, one
//   quotient bit per clock. Add/subtract per step uses an XOR-based conditional
//   complement of the divisor plus carry-in. Sits beside the multiplier in the
//   MIPS32 ALU/HI-LO datapath; driven by a start/done handshake.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>= 4)
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request; sampled only in IDLE
//   signed_op    in   1      1 = two's-complement divide (DIV), 0 = unsigned (DIVU)
//   dividend     in   WIDTH  numerator, sampled with start
//   divisor      in   WIDTH  denominator, sampled with start
//   busy         out  1      high from the cycle after start is accepted until done
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  result (LO)
//   remainder    out  WIDTH  result (HI)
//   div_by_zero  out  1      set with done when divisor == 0
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0.
//   Reset mid-operation aborts immediately: no done pulse, outputs zeroed.
//   FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
//   - IDLE: start=1 latches operands, signed_op; captures operand magnitudes
//     (abs value if signed_op and MSB=1) and result signs; count=0.
//     If divisor==0 go to DONE directly, else CALC.
//   - CALC: partial remainder P is WIDTH+1 bits, signed. Each cycle:
//     {P,A} <<= 1; if P_old >= 0 then P -= D else P += D (D XORed with
//     sign-replicated op bit, carry-in = op bit); new quotient LSB = ~P[WIDTH].
//     Exactly WIDTH cycles, count increments 0..WIDTH-1, then FIX.
//   - FIX (1 cycle): if P < 0, P += D. Negate quotient if signs differ;
//     negate remainder if dividend was negative (signed only). Go to DONE.
//   - DONE (1 cycle): done=1, busy=0, outputs updated this cycle; -> IDLE.
//   Latency: done high WIDTH+2 edges after the edge sampling start (normal);
//   1 edge after for divide-by-zero.
//   busy=1 in CALC and FIX only. quotient/remainder/div_by_zero hold until the
//   next accepted start; they do not change while busy.
//   start while busy or in DONE: ignored, no queueing. start held high
//   continuously: a new operation is accepted on the first IDLE cycle.
//   Signed semantics: quotient truncates toward zero; remainder sign = dividend sign.
//   Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
//   Signed overflow (-2^(WIDTH-1) / -1): quotient = 0x80000000, remainder = 0,
//   div_by_zero=0; falls out of magnitude arithmetic with no special case.
//   Unsigned magnitude of 0x80000000 is handled in full WIDTH bits (no overflow).
// TESTING
//   1. Unsigned 100/7 -> q=14, r=2, done exactly 34 cycles after start, busy 32+1 cycles.
//   2. Signed -100/7 -> q=0xFFFFFFF2, r=0xFFFFFFFE; signed 100/-7 -> q=0xFFFFFFF2, r=2.
//   3. Divisor 0, dividend 0x1234 -> done 1 cycle later, q=0xFFFFFFFF,
//      r=0x1234, div_by_zero=1; next normal divide clears div_by_zero.
//   4. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; unsigned
//      0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
//   5. start pulsed at cycle 10 of an operation with new operands -> ignored,
//      first result unchanged, single done pulse.
//   6. rst asserted at cycle 15 of CALC -> next cycle busy=0, outputs 0, no done;
//      a start after reset completes normally.
//   Plus random signed/unsigned sweep vs behavioural / and % reference model.

Source files
------------

// File: rtl/nonrestoring_divider_32.sv
// Sequential non-restoring integer divider (DIV/DIVU) for the MIPS32 HI/LO path.
// One quotient bit per clock; operands are reduced to magnitudes up front and
// the result signs are applied in a single fix-up cycle.
module nonrestoring_divider_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  // Control state (reset)
  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic            dbz_q, dbz_d;

  // Datapath state (no reset needed; always loaded before use)
  logic signed [WIDTH:0] p_q, p_d;
  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      dv_q, dv_d;
  logic                  qneg_q, qneg_d;
  logic                  rneg_q, rneg_d;

  // Combinational step values
  logic [WIDTH:0]        p_shift;
  logic [WIDTH:0]        addend;
  logic [WIDTH:0]        cin_vec;
  logic                  sub_op;
  logic signed [WIDTH:0] p_step;
  logic signed [WIDTH:0] p_fix;
  logic                  sgn_a;
  logic                  sgn_b;

  // Two's-complement negate when neg is set; also yields |v| for a negative v.
  // The magnitude of the most negative value stays correct as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  // One non-restoring step: shift {P,A} left, then subtract D if P was
  // non-negative, otherwise add D. Subtraction is D inverted plus carry-in.
  // P only needs WIDTH+1 bits: the post-step value always lies in [-D, D).
  always_comb begin
    p_shift = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
    sub_op  = ~p_q[WIDTH];
    addend  = {1'b0, dv_q} ^ {(WIDTH+1){sub_op}};
    cin_vec = {{WIDTH{1'b0}}, sub_op};
    p_step  = $signed(p_shift + addend + cin_vec);
    p_fix   = p_q[WIDTH] ? (p_q + $signed({1'b0, dv_q})) : p_q;
    sgn_a   = signed_op & dividend[WIDTH-1];
    sgn_b   = signed_op & divisor[WIDTH-1];
  end

  // Next-state and next-value logic for the IDLE -> CALC -> FIX -> DONE sequence
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    p_d     = p_q;
    a_d     = a_q;
    dv_d    = dv_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = cond_neg(dividend, sgn_a);
          dv_d    = cond_neg(divisor, sgn_b);
          p_d     = '0;
          count_d = '0;
          qneg_d  = sgn_a ^ sgn_b;
          rneg_d  = sgn_a;
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        p_d     = p_step;
        a_d     = {a_q[WIDTH-2:0], ~p_step[WIDTH]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        p_d     = p_fix;
        quot_d  = cond_neg(a_q, qneg_q);
        rem_d   = cond_neg(p_fix[WIDTH-1:0], rneg_q);
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and result registers, cleared by synchronous reset (also aborts an operation)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Datapath registers: partial remainder, dividend/quotient shifter, divisor, result signs
  always_ff @(posedge clk) begin
    p_q    <= p_d;
    a_q    <= a_d;
    dv_q   <= dv_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nonrestoring_divider_32.sv
// Self-checking bench for nonrestoring_divider_32: directed vector table,
// hand-written handshake/reset sequences and a random sweep against / and %.
module tb_nonrestoring_divider_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  nonrestoring_divider_32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        ez;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero
  task automatic ref_div(input logic sop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (sop) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endtask

  // Issue one operation and wait (bounded) for done; lat counts edges from the sampling edge
  task automatic run_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output int lat, output int bc, output logic done_after);
    int n;
    @(negedge clk);
    start     = 1'b1;
    signed_op = sop;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    n     = 1;
    bc    = 0;
    while (!done && n < 100) begin
      if (busy) bc++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    lat = n;
    q   = quotient;
    r   = remainder;
    z   = div_by_zero;
    @(posedge clk);
    #1;
    done_after = done;
  endtask

  vec_t        vecs[14];
  logic [31:0] q, r, eq, er;
  logic        z, ez, da;
  int          lat, bc;
  int          pulses, chg, k1, k2;
  logic [31:0] prevq, gotq, gotr;
  logic        busy_at36;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0};
    vecs[2]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
    vecs[3]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
    vecs[4]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[7]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[8]  = '{1'b1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          1'b0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    vecs[11] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[12] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1'b1};
    vecs[13] = '{1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].sop, vecs[i].a, vecs[i].b, q, r, z, lat, bc, da);
      chk($sformatf("vec%0d_quotient", i), q, vecs[i].eq);
      chk($sformatf("vec%0d_remainder", i), r, vecs[i].er);
      chk($sformatf("vec%0d_dbz", i), {31'd0, z}, {31'd0, vecs[i].ez});
      chk($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].ez ? 32'd1 : 32'd34);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bc), vecs[i].ez ? 32'd0 : 32'd33);
      chk($sformatf("vec%0d_single_done", i), {31'd0, da}, 32'd0);
    end

    // start pulsed mid-operation with new operands must be ignored
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd10;
    prevq = quotient; chg = 0; pulses = 0; lat = 0; gotq = '0; gotr = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (busy && quotient !== prevq) chg++;
      if (done) begin
        pulses++;
        if (lat == 0) lat = k;
        gotq = quotient;
        gotr = remainder;
      end
      if (k == 1 || k == 11) start = 1'b0;
      else if (k == 10) begin
        start = 1'b1; dividend = 32'd77; divisor = 32'd5;
      end
    end
    chk("ignore_quotient", gotq, 32'd100);
    chk("ignore_remainder", gotr, 32'd0);
    chk("ignore_done_pulses", 32'(pulses), 32'd1);
    chk("ignore_latency", 32'(lat), 32'd34);
    chk("hold_while_busy", 32'(chg), 32'd0);

    // start held high: back-to-back operations, accepted on the first IDLE cycle
    @(negedge clk);
    start = 1'b1; signed_op = 1'b1; dividend = 32'hFFFF_FFCE; divisor = 32'd5;
    k1 = 0; k2 = 0; pulses = 0; busy_at36 = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk);
      #1;
      if (k == 36) busy_at36 = busy;
      if (done) begin
        pulses++;
        if (k1 == 0) k1 = k;
        else begin
          k2 = k;
          start = 1'b0;
          gotq = quotient;
        end
      end
    end
    start = 1'b0;
    chk("held_first_done", 32'(k1), 32'd34);
    chk("held_restart_busy", {31'd0, busy_at36}, 32'd1);
    chk("held_second_done", 32'(k2), 32'd69);
    chk("held_pulses", 32'(pulses), 32'd2);
    chk("held_quotient", gotq, 32'hFFFF_FFF6);

    // Reset in the middle of CALC aborts the operation
    @(negedge clk);
    start = 1'b1; signed_op = 1'b0; dividend = 32'd77777; divisor = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_op(1'b0, 32'd77777, 32'd3, q, r, z, lat, bc, da);
    chk("after_abort_quotient", q, 32'd25925);
    chk("after_abort_remainder", r, 32'd2);
    chk("after_abort_latency", 32'(lat), 32'd34);

    // Random sweep against the reference model
    for (int i = 0; i < 200; i++) begin
      logic        sop;
      logic [31:0] a, b;
      sop = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      if (i % 4 == 0) b = $urandom_range(0, 15);
      if (i % 5 == 1) b = 32'hFFFF_FFFF - $urandom_range(0, 7);
      if (i % 7 == 2) a = 32'h8000_0000;
      if (i % 16 == 3) b = 32'd0;
      ref_div(sop, a, b, eq, er, ez);
      run_op(sop, a, b, q, r, z, lat, bc, da);
      chk($sformatf("rnd%0d_quotient", i), q, eq);
      chk($sformatf("rnd%0d_remainder", i), r, er);
      chk($sformatf("rnd%0d_dbz", i), {31'd0, z}, {31'd0, ez});
      chk($sformatf("rnd%0d_latency", i), 32'(lat), ez ? 32'd1 : 32'd34);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
